// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode and ALU operation encodings, operand-B
// select codes and the control bundle carried from decode into execute.
package decode_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_BGT  = 4'h5,
        OP_BEQ  = 4'h6,
        OP_B    = 4'h7,
        OP_MOV  = 4'h8,
        OP_ADDI = 4'h9,
        OP_CMP  = 4'hA,
        OP_LSL  = 4'hB,
        OP_LSR  = 4'hC,
        OP_LDR  = 4'hD,
        OP_STR  = 4'hE,
        OP_RSVD = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_LSL = 3'b100,
        ALU_LSR = 3'b101
    } aluop_e;

    // Operand-B select: rd2, rd3, sign-extended imm[7:0], zero-extended imm[11:0]
    localparam logic [1:0] RI_RD2    = 2'b00;
    localparam logic [1:0] RI_RD3    = 2'b01;
    localparam logic [1:0] RI_SIMM8  = 2'b10;
    localparam logic [1:0] RI_ZIMM12 = 2'b11;

    typedef struct packed {
        logic   wbs;
        logic   wme;
        logic   mm;
        aluop_e alu_op;
        logic   wm;
        logic   am;
        logic   ni;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetched instruction, flags and operands in; IF/ID contents,
// combinational operand/writeback controls and registered execute controls out.
interface decode_stage_if #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16
);
    logic [INSTR_W-1:0] instruction_in;
    logic               flagN;
    logic               flagZ;
    logic [DATA_W-1:0]  srcA_in;
    logic [DATA_W-1:0]  srcB_in;

    logic [INSTR_W-1:0] instruction_decode;
    logic [1:0]         ri;
    logic               wre;
    logic               wbs_execute;
    logic               wme_execute;
    logic               mm_execute;
    logic               wm_execute;
    logic               am_execute;
    logic               ni_execute;
    logic [2:0]         ALUop_execute;
    logic [DATA_W-1:0]  srcA_execute;
    logic [DATA_W-1:0]  srcB_execute;

    modport master (
        output instruction_in, flagN, flagZ, srcA_in, srcB_in,
        input  instruction_decode, ri, wre,
        input  wbs_execute, wme_execute, mm_execute, wm_execute, am_execute, ni_execute,
        input  ALUop_execute, srcA_execute, srcB_execute
    );

    modport slave (
        input  instruction_in, flagN, flagZ, srcA_in, srcB_in,
        output instruction_decode, ri, wre,
        output wbs_execute, wme_execute, mm_execute, wm_execute, am_execute, ni_execute,
        output ALUop_execute, srcA_execute, srcB_execute
    );
endinterface

// File: rtl/decode_stage_control_decoder.sv
// Purely combinational opcode decoder; branch condition resolves from the live
// flags so a flag change is visible in the same cycle.
module control_decoder
    import decode_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       flag_n,
    input  logic       flag_z,
    output ctrl_t      ctrl,
    output logic [1:0] ri,
    output logic       wre
);

    always_comb begin
        ctrl = CTRL_NOP;
        ri   = RI_RD2;
        wre  = 1'b0;
        case (opcode_e'(opcode))
            OP_ADD:  begin ctrl.alu_op = ALU_ADD; wre = 1'b1; end
            OP_SUB:  begin ctrl.alu_op = ALU_SUB; wre = 1'b1; end
            OP_AND:  begin ctrl.alu_op = ALU_AND; wre = 1'b1; end
            OP_OR:   begin ctrl.alu_op = ALU_OR;  wre = 1'b1; end
            OP_BGT:  begin ri = RI_ZIMM12; ctrl.ni = ~flag_n & ~flag_z; end
            OP_BEQ:  begin ri = RI_ZIMM12; ctrl.ni = flag_z; end
            OP_B:    begin ri = RI_ZIMM12; ctrl.ni = 1'b1; end
            OP_MOV:  begin ri = RI_SIMM8; wre = 1'b1; ctrl.am = 1'b1; end
            OP_ADDI: begin ri = RI_SIMM8; wre = 1'b1; end
            OP_CMP:  ctrl.alu_op = ALU_SUB;
            OP_LSL:  begin ctrl.alu_op = ALU_LSL; ri = RI_SIMM8; wre = 1'b1; end
            OP_LSR:  begin ctrl.alu_op = ALU_LSR; ri = RI_SIMM8; wre = 1'b1; end
            OP_LDR:  begin ri = RI_SIMM8; wre = 1'b1; ctrl.wbs = 1'b1; ctrl.mm = 1'b1; end
            OP_STR:  begin ri = RI_SIMM8; ctrl.wme = 1'b1; ctrl.mm = 1'b1; ctrl.wm = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, control decoder and ID/EX register.
// Optional DECODE_STAGE_FLUSH_EN adds a flush input that bubbles both registers.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef DECODE_STAGE_FLUSH_EN
    input  logic flush,
`endif
    decode_stage_if.slave bus
);

    logic [INSTR_W-1:0] instr_p1;
    ctrl_t              ctrl_p1;
    ctrl_t              ctrl_p2;
    logic [DATA_W-1:0]  srcA_p2;
    logic [DATA_W-1:0]  srcB_p2;

    control_decoder u_dec (
        .opcode (instr_p1[INSTR_W-1 -: 4]),
        .flag_n (bus.flagN),
        .flag_z (bus.flagZ),
        .ctrl   (ctrl_p1),
        .ri     (bus.ri),
        .wre    (bus.wre)
    );

    // p1: IF/ID and p2: ID/EX boundaries; reset wins over flush
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p1 <= '0;
            ctrl_p2  <= CTRL_NOP;
            srcA_p2  <= '0;
            srcB_p2  <= '0;
        end
`ifdef DECODE_STAGE_FLUSH_EN
        else if (flush) begin
            instr_p1 <= '0;
            ctrl_p2  <= CTRL_NOP;
            srcA_p2  <= '0;
            srcB_p2  <= '0;
        end
`endif
        else begin
            instr_p1 <= bus.instruction_in;
            ctrl_p2  <= ctrl_p1;
            srcA_p2  <= bus.srcA_in;
            srcB_p2  <= bus.srcB_in;
        end
    end

    assign bus.instruction_decode = instr_p1;
    assign bus.wbs_execute        = ctrl_p2.wbs;
    assign bus.wme_execute        = ctrl_p2.wme;
    assign bus.mm_execute         = ctrl_p2.mm;
    assign bus.ALUop_execute      = ctrl_p2.alu_op;
    assign bus.wm_execute         = ctrl_p2.wm;
    assign bus.am_execute         = ctrl_p2.am;
    assign bus.ni_execute         = ctrl_p2.ni;
    assign bus.srcA_execute       = srcA_p2;
    assign bus.srcB_execute       = srcB_p2;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by random traffic, all
// compared against a table-driven two-deep pipeline model.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    decode_stage_if bus ();
`ifdef DECODE_STAGE_FLUSH_EN
    logic flush = 1'b0;
`endif

    decode_stage dut (
        .clk   (clk),
        .rst   (rst),
`ifdef DECODE_STAGE_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    // Model state: decode register, execute control {wbs,wme,mm,alu[2:0],wm,am,ni}, operands
    logic [15:0] m_id;
    logic [8:0]  m_ex;
    logic [15:0] m_a, m_b;

    // Row layout: {wbs,wme,mm, alu[2:0], wm,am,ni, ri[1:0], wre}
    function automatic logic [11:0] ref_decode(input logic [15:0] ins, input logic n, input logic z);
        logic [11:0] row;
        case (ins[15:12])
            4'h1: row = {3'b000, 3'b000, 3'b000, 2'b00, 1'b1};
            4'h2: row = {3'b000, 3'b001, 3'b000, 2'b00, 1'b1};
            4'h3: row = {3'b000, 3'b010, 3'b000, 2'b00, 1'b1};
            4'h4: row = {3'b000, 3'b011, 3'b000, 2'b00, 1'b1};
            4'h5: row = {3'b000, 3'b000, 2'b00, (~n & ~z), 2'b11, 1'b0};
            4'h6: row = {3'b000, 3'b000, 2'b00, z, 2'b11, 1'b0};
            4'h7: row = {3'b000, 3'b000, 3'b001, 2'b11, 1'b0};
            4'h8: row = {3'b000, 3'b000, 3'b010, 2'b10, 1'b1};
            4'h9: row = {3'b000, 3'b000, 3'b000, 2'b10, 1'b1};
            4'hA: row = {3'b000, 3'b001, 3'b000, 2'b00, 1'b0};
            4'hB: row = {3'b000, 3'b100, 3'b000, 2'b10, 1'b1};
            4'hC: row = {3'b000, 3'b101, 3'b000, 2'b10, 1'b1};
            4'hD: row = {3'b101, 3'b000, 3'b000, 2'b10, 1'b1};
            4'hE: row = {3'b011, 3'b000, 3'b100, 2'b10, 1'b0};
            default: row = '0;
        endcase
        return row;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] ins, input logic n, input logic z,
                         input logic [15:0] a, input logic [15:0] b);
        bus.instruction_in = ins;
        bus.flagN = n;
        bus.flagZ = z;
        bus.srcA_in = a;
        bus.srcB_in = b;
    endtask

    // Advance one edge, update the model from the values present at that edge, then compare
    task automatic cycle(input string tag);
        logic [11:0] d;
        logic        do_clear;
        @(posedge clk);
        do_clear = rst;
`ifdef DECODE_STAGE_FLUSH_EN
        do_clear = do_clear | flush;
`endif
        if (do_clear) begin
            m_id = '0; m_ex = '0; m_a = '0; m_b = '0;
        end else begin
            m_ex = ref_decode(m_id, bus.flagN, bus.flagZ) >> 3;
            m_a  = bus.srcA_in;
            m_b  = bus.srcB_in;
            m_id = bus.instruction_in;
        end
        #1;
        d = ref_decode(m_id, bus.flagN, bus.flagZ);
        chk({tag, ".id"},   bus.instruction_decode, m_id);
        chk({tag, ".ri"},   bus.ri, d[2:1]);
        chk({tag, ".wre"},  bus.wre, d[0]);
        chk({tag, ".ctrl"}, {bus.wbs_execute, bus.wme_execute, bus.mm_execute, bus.ALUop_execute,
                             bus.wm_execute, bus.am_execute, bus.ni_execute}, m_ex);
        chk({tag, ".srcA"}, bus.srcA_execute, m_a);
        chk({tag, ".srcB"}, bus.srcB_execute, m_b);
    endtask

    initial begin
        m_id = '0; m_ex = '0; m_a = '0; m_b = '0;
        rst = 1'b1;
        drive(16'h1234, 1'b1, 1'b0, 16'hBEEF, 16'hCAFE);
        cycle("reset0");
        cycle("reset1");
        chk("reset.ri_nop", bus.ri, 2'b00);
        chk("reset.wre_nop", bus.wre, 1'b0);
        rst = 1'b0;

        // mov r1,#7
        drive(16'h8107, 1'b0, 1'b0, 16'h0, 16'h0);
        cycle("mov");
        chk("mov.id", bus.instruction_decode, 16'h8107);
        chk("mov.ri", bus.ri, 2'b10);
        chk("mov.wre", bus.wre, 1'b1);
        // add with held operands
        drive(16'h1012, 1'b0, 1'b0, 16'h0007, 16'h0009);
        cycle("add");
        chk("mov.am_ex", bus.am_execute, 1'b1);
        chk("mov.alu_ex", bus.ALUop_execute, 3'b000);
        chk("add.ri", bus.ri, 2'b00);
        chk("add.wre", bus.wre, 1'b1);
        drive(16'h5005, 1'b0, 1'b0, 16'h0007, 16'h0009);
        cycle("bgt");
        chk("add.srcA_ex", bus.srcA_execute, 16'h0007);
        chk("add.srcB_ex", bus.srcB_execute, 16'h0009);
        chk("add.am_ex", bus.am_execute, 1'b0);
        chk("bgt.ri", bus.ri, 2'b11);
        chk("bgt.wre", bus.wre, 1'b0);
        bus.flagN = 1'b1;
        cycle("bgt_n1");
        chk("bgt_n1.ni_ex", bus.ni_execute, 1'b0);
        bus.flagN = 1'b0;
        cycle("bgt_n0");
        chk("bgt_n0.ni_ex", bus.ni_execute, 1'b1);

        // back-to-back sequence, then reset interrupts it
        drive(16'h8107, 1'b0, 1'b0, 16'h0011, 16'h0022); cycle("seq0");
        drive(16'h8209, 1'b0, 1'b0, 16'h0033, 16'h0044); cycle("seq1");
        drive(16'h1012, 1'b0, 1'b0, 16'h0055, 16'h0066); cycle("seq2");
        drive(16'h5005, 1'b0, 1'b0, 16'h0077, 16'h0088); cycle("seq3");
        rst = 1'b1;
        cycle("seq_rst");
        chk("seq_rst.id", bus.instruction_decode, 16'h0000);
        chk("seq_rst.ni_ex", bus.ni_execute, 1'b0);
        rst = 1'b0;

`ifdef DECODE_STAGE_FLUSH_EN
        drive(16'h1012, 1'b0, 1'b0, 16'h0001, 16'h0002); cycle("fl_load");
        flush = 1'b1;
        cycle("flush");
        chk("flush.alu_ex", bus.ALUop_execute, 3'b000);
        chk("flush.id", bus.instruction_decode, 16'h0000);
        flush = 1'b0;
        drive(16'hE123, 1'b0, 1'b0, 16'h0003, 16'h0004); cycle("fl_str");
        rst = 1'b1; flush = 1'b1;
        cycle("rst_over_flush");
        rst = 1'b0; flush = 1'b0;
`endif

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            drive(16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            rst = ($urandom_range(0, 15) == 0);
`ifdef DECODE_STAGE_FLUSH_EN
            flush = ($urandom_range(0, 15) == 0);
`endif
            cycle("rand");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
